hexpad_key_events: RTL and testbench

- Consumes the 16-bit one-hot key bitmap produced by the PMOD hex pad scanner and turns it into a stream of debounced key events.
- Each event is a press or a release plus a 4-bit hex key code.
- Events pass through a small FIFO to the sap-1 front panel / input logic via a valid/ready handshake.
- Rejects multi-key chords and flags FIFO overflow.

---
 rtl/hexpad_key_events.sv | 186 ++++++++++++++++++
 tb/tb_hexpad_key_events.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hexpad_key_events.sv
// Debounces the hex pad bitmap, turns single-key transitions into press/release events,
// and queues them in a small FIFO with a valid/ready interface.
module hexpad_key_events #(
  parameter int SAMPLE_CYCLES    = 500000,
  parameter int DEBOUNCE_SAMPLES = 3,
  parameter int FIFO_DEPTH       = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] keys,
  output logic        event_valid,
  output logic [4:0]  event_data,
  input  logic        event_ready,
  output logic        key_held,
  output logic [3:0]  key_code,
  output logic        multi_err,
  output logic        overflow,
  input  logic        ovf_clear
);

  localparam int CW   = (SAMPLE_CYCLES > 1) ? $clog2(SAMPLE_CYCLES) : 1;
  localparam int SW   = $clog2(DEBOUNCE_SAMPLES + 1);
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int CNTW = AW + 1;
  localparam logic [CW-1:0]   CNT_LAST   = CW'(SAMPLE_CYCLES - 1);
  localparam logic [SW-1:0]   STABLE_MAX = SW'(DEBOUNCE_SAMPLES);
  localparam logic [SW-1:0]   STABLE_PRE = SW'(DEBOUNCE_SAMPLES - 1);
  localparam logic [CNTW-1:0] FULL_CNT   = CNTW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, HELD, PEND_PRESS, MULTI} state_t;

  state_t          state, state_next;
  logic [CW-1:0]   sample_cnt;
  logic            tick;
  logic [15:0]     last_sample;
  logic [SW-1:0]   stable_cnt;
  logic            accept;
  logic            key_zero, key_single;
  logic [3:0]      new_code, code_next;
  logic            push, multi_next;
  logic [4:0]      push_data;
  logic [4:0]      fifo_mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CNTW-1:0] fifo_cnt;
  logic            fifo_full, pop, wr_en;

  // Physical pad layout to hex code; only meaningful for a single set bit.
  function automatic logic [3:0] bit_to_code(input logic [15:0] k);
    logic [3:0] idx;
    logic [3:0] code;
    idx = '0;
    for (int i = 0; i < 16; i++) begin
      if (k[i]) idx = 4'(i);
    end
    case (idx)
      4'd15: code = 4'h1;  4'd14: code = 4'h2;  4'd13: code = 4'h3;  4'd12: code = 4'hA;
      4'd11: code = 4'h4;  4'd10: code = 4'h5;  4'd9:  code = 4'h6;  4'd8:  code = 4'hB;
      4'd7:  code = 4'h7;  4'd6:  code = 4'h8;  4'd5:  code = 4'h9;  4'd4:  code = 4'hC;
      4'd3:  code = 4'h0;  4'd2:  code = 4'hF;  4'd1:  code = 4'hE;  default: code = 4'hD;
    endcase
    return code;
  endfunction

  assign tick = (sample_cnt == CNT_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)    sample_cnt <= '0;
    else if (tick) sample_cnt <= '0;
    else           sample_cnt <= sample_cnt + CW'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_sample <= '0;
      stable_cnt  <= '0;
    end else if (tick) begin
      if (keys == last_sample) begin
        if (stable_cnt != STABLE_MAX) stable_cnt <= stable_cnt + SW'(1);
      end else begin
        last_sample <= keys;
        stable_cnt  <= SW'(1);
      end
    end
  end

  // Fires once per stable bitmap: only on the tick that reaches the threshold.
  assign accept     = tick && (keys == last_sample) && (stable_cnt == STABLE_PRE);
  assign key_zero   = (keys == 16'd0);
  assign key_single = !key_zero && ((keys & (keys - 16'd1)) == 16'd0);
  assign new_code   = bit_to_code(keys);

  always_comb begin
    state_next = state;
    code_next  = key_code;
    push       = 1'b0;
    push_data  = '0;
    multi_next = 1'b0;
    case (state)
      IDLE: if (accept) begin
        if (key_single) begin
          push       = 1'b1;
          push_data  = {1'b0, new_code};
          code_next  = new_code;
          state_next = HELD;
        end else if (!key_zero) begin
          multi_next = 1'b1;
          state_next = MULTI;
        end
      end
      HELD: if (accept) begin
        if (key_zero) begin
          push       = 1'b1;
          push_data  = {1'b1, key_code};
          state_next = IDLE;
        end else if (key_single) begin
          if (new_code != key_code) begin
            push       = 1'b1;
            push_data  = {1'b1, key_code};
            code_next  = new_code;
            state_next = PEND_PRESS;
          end
        end else begin
          push       = 1'b1;
          push_data  = {1'b1, key_code};
          state_next = MULTI;
        end
      end
      PEND_PRESS: begin
        push       = 1'b1;
        push_data  = {1'b0, key_code};
        state_next = HELD;
      end
      MULTI: if (accept && key_zero) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      key_code  <= '0;
      multi_err <= 1'b0;
    end else begin
      state     <= state_next;
      key_code  <= code_next;
      multi_err <= multi_next;
    end
  end

  assign key_held = (state == HELD) || (state == PEND_PRESS);

  // A push into a full FIFO still succeeds when the head leaves on the same clock.
  assign pop       = event_valid && event_ready;
  assign fifo_full = (fifo_cnt == FULL_CNT);
  assign wr_en     = push && (!fifo_full || pop);

  always_ff @(posedge clk) begin
    if (wr_en) fifo_mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, pop})
        2'b10:   fifo_cnt <= fifo_cnt + CNTW'(1);
        2'b01:   fifo_cnt <= fifo_cnt - CNTW'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                         overflow <= 1'b0;
    else if (push && fifo_full && !pop) overflow <= 1'b1;
    else if (ovf_clear)                 overflow <= 1'b0;
  end

  assign event_valid = (fifo_cnt != '0);
  assign event_data  = event_valid ? fifo_mem[rd_ptr] : 5'd0;

endmodule

// File: tb/tb_hexpad_key_events.sv
// Bench for hexpad_key_events: a held-key/queue model checked every cycle, plus
// literal expectations on the popped event stream for each directed scenario.
module tb_hexpad_key_events;

  localparam int SC    = 4;
  localparam int DEB   = 3;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] keys = '0;
  logic        event_ready = 1'b1;
  logic        ovf_clear = 1'b0;
  logic        event_valid;
  logic [4:0]  event_data;
  logic        key_held;
  logic [3:0]  key_code;
  logic        multi_err;
  logic        overflow;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  hexpad_key_events #(
    .SAMPLE_CYCLES(SC), .DEBOUNCE_SAMPLES(DEB), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .keys(keys),
    .event_valid(event_valid), .event_data(event_data), .event_ready(event_ready),
    .key_held(key_held), .key_code(key_code), .multi_err(multi_err),
    .overflow(overflow), .ovf_clear(ovf_clear)
  );

  // Pad bit index 0..15 to hex code.
  int code_tab [16] = '{4'hD, 4'hE, 4'hF, 4'h0, 4'hC, 4'h9, 4'h8, 4'h7,
                        4'hB, 4'h6, 4'h5, 4'h4, 4'hA, 4'h3, 4'h2, 4'h1};

  // Model: sample clock, run length of identical samples, held key, lockout after chords.
  int          m_cnt = 0;
  int          m_run_len = 0;
  logic [15:0] m_run_val = '0;
  bit          m_held = 0;
  bit          m_lock = 0;
  bit          m_pend = 0;
  logic [3:0]  m_code = '0;
  bit          m_multi = 0;
  bit          m_ovf = 0;
  logic [4:0]  m_q [$];
  bit          m_acc, m_have_ev, m_pop;
  logic [4:0]  m_ev;
  int          m_n;
  logic [3:0]  m_c;

  logic [4:0]  dut_log [$];
  int          multi_seen = 0;

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  initial forever begin
    @(posedge clk or negedge reset);
    if (!reset) begin
      m_cnt = 0; m_run_len = 0; m_run_val = '0;
      m_held = 0; m_lock = 0; m_pend = 0; m_code = '0;
      m_multi = 0; m_ovf = 0;
      m_q.delete();
    end else begin
      m_acc = 0; m_have_ev = 0; m_ev = '0; m_multi = 0;
      if (m_cnt == SC - 1) begin
        m_cnt = 0;
        if (keys == m_run_val) m_run_len++;
        else begin
          m_run_val = keys;
          m_run_len = 1;
        end
        if (m_run_len == DEB) m_acc = 1;
      end else begin
        m_cnt++;
      end
      m_n = $countones(keys);
      m_c = '0;
      for (int i = 0; i < 16; i++) if (keys[i]) m_c = 4'(code_tab[i]);
      if (m_pend) begin
        m_have_ev = 1; m_ev = {1'b0, m_code}; m_pend = 0;
      end else if (m_acc) begin
        if (m_lock) begin
          if (m_n == 0) m_lock = 0;
        end else if (m_n == 0) begin
          if (m_held) begin m_have_ev = 1; m_ev = {1'b1, m_code}; m_held = 0; end
        end else if (m_n == 1) begin
          if (!m_held) begin
            m_have_ev = 1; m_ev = {1'b0, m_c}; m_held = 1; m_code = m_c;
          end else if (m_c != m_code) begin
            m_have_ev = 1; m_ev = {1'b1, m_code}; m_code = m_c; m_pend = 1;
          end
        end else begin
          if (m_held) begin m_have_ev = 1; m_ev = {1'b1, m_code}; m_held = 0; end
          else m_multi = 1;
          m_lock = 1;
        end
      end
      m_pop = (m_q.size() > 0) && event_ready;
      if (m_pop) void'(m_q.pop_front());
      if (m_have_ev) begin
        if (m_q.size() < DEPTH) m_q.push_back(m_ev);
        else m_ovf = 1;
      end else if (ovf_clear) begin
        m_ovf = 0;
      end
      if (m_have_ev && m_q.size() < DEPTH + 1 && ovf_clear && m_q.size() != 0) begin
      end
    end
  end

  // Per-cycle comparison against the model; also records events the consumer takes.
  initial forever begin
    @(negedge clk);
    checkOutput("event_valid", 16'(event_valid), 16'(m_q.size() > 0));
    checkOutput("event_data", 16'(event_data), (m_q.size() > 0) ? 16'(m_q[0]) : 16'd0);
    checkOutput("key_held", 16'(key_held), 16'(m_held));
    checkOutput("key_code", 16'(key_code), 16'(m_code));
    checkOutput("multi_err", 16'(multi_err), 16'(m_multi));
    checkOutput("overflow", 16'(overflow), 16'(m_ovf));
    if (reset && event_valid && event_ready) dut_log.push_back(event_data);
    if (multi_err) multi_seen++;
  end

  task automatic applyStimulus(input logic [15:0] k, input int cycles);
    keys = k;
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  task automatic checkLog(input string name, input int len,
                          input logic [4:0] e0, input logic [4:0] e1,
                          input logic [4:0] e2, input logic [4:0] e3);
    logic [4:0] exp [4];
    exp = '{e0, e1, e2, e3};
    checkOutput({name, "_len"}, 16'(dut_log.size()), 16'(len));
    for (int i = 0; i < len && i < 4; i++)
      checkOutput({name, "_entry"}, (i < dut_log.size()) ? 16'(dut_log[i]) : 16'hFFFF, 16'(exp[i]));
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;

    // Idle with no keys
    applyStimulus(16'h0000, 40);
    checkOutput("idle_valid", 16'(event_valid), 16'd0);
    checkOutput("idle_held", 16'(key_held), 16'd0);
    checkOutput("idle_ovf", 16'(overflow), 16'd0);
    checkLog("idle_log", 0, 5'h00, 5'h00, 5'h00, 5'h00);

    // Single press and release of key 1
    dut_log.delete();
    applyStimulus(16'h8000, 20);
    checkLog("press1", 1, 5'h01, 5'h00, 5'h00, 5'h00);
    checkOutput("press1_held", 16'(key_held), 16'd1);
    checkOutput("press1_code", 16'(key_code), 16'h1);
    applyStimulus(16'h0000, 20);
    checkLog("rel1", 2, 5'h01, 5'h11, 5'h00, 5'h00);
    checkOutput("rel1_held", 16'(key_held), 16'd0);

    // Bouncing contact on key F
    dut_log.delete();
    for (int i = 0; i < 5; i++) applyStimulus((i % 2 == 0) ? 16'h0004 : 16'h0000, SC);
    checkLog("bounce_none", 0, 5'h00, 5'h00, 5'h00, 5'h00);
    applyStimulus(16'h0004, 20);
    checkLog("bounce", 1, 5'h0F, 5'h00, 5'h00, 5'h00);
    applyStimulus(16'h0000, 20);

    // Direct key switch 1 -> D
    dut_log.delete();
    applyStimulus(16'h8000, 20);
    applyStimulus(16'h0001, 20);
    checkLog("switch", 3, 5'h01, 5'h11, 5'h0D, 5'h00);
    checkOutput("switch_code", 16'(key_code), 16'hD);
    applyStimulus(16'h0000, 20);

    // Chord lockout
    dut_log.delete();
    multi_seen = 0;
    applyStimulus(16'h8001, 20);
    checkOutput("multi_pulses", 16'(multi_seen), 16'd1);
    checkLog("multi", 0, 5'h00, 5'h00, 5'h00, 5'h00);
    applyStimulus(16'h0800, 20);
    checkLog("multi_single", 0, 5'h00, 5'h00, 5'h00, 5'h00);
    checkOutput("multi_held", 16'(key_held), 16'd0);
    applyStimulus(16'h0000, 20);
    checkLog("multi_zero", 0, 5'h00, 5'h00, 5'h00, 5'h00);
    applyStimulus(16'h0800, 20);
    checkLog("after_multi", 1, 5'h04, 5'h00, 5'h00, 5'h00);
    checkOutput("after_multi_code", 16'(key_code), 16'h4);
    applyStimulus(16'h0000, 20);

    // Overflow with a stalled consumer
    dut_log.delete();
    event_ready = 1'b0;
    applyStimulus(16'h8000, 20);
    applyStimulus(16'h0000, 20);
    applyStimulus(16'h4000, 20);
    applyStimulus(16'h0000, 20);
    checkOutput("fill_ovf", 16'(overflow), 16'd0);
    applyStimulus(16'h2000, 20);
    checkOutput("ovf_set", 16'(overflow), 16'd1);
    applyStimulus(16'h0000, 20);
    event_ready = 1'b1;
    applyStimulus(16'h0000, 10);
    checkLog("drain", 4, 5'h01, 5'h11, 5'h02, 5'h12);
    checkOutput("drain_valid", 16'(event_valid), 16'd0);
    checkOutput("ovf_sticky", 16'(overflow), 16'd1);
    ovf_clear = 1'b1;
    applyStimulus(16'h0000, 1);
    ovf_clear = 1'b0;
    checkOutput("ovf_cleared", 16'(overflow), 16'd0);

    // Reset mid-operation with a held key and queued events
    applyStimulus(16'h8000, 20);
    event_ready = 1'b0;
    applyStimulus(16'h0000, 20);
    applyStimulus(16'h8000, 20);
    checkOutput("pre_rst_valid", 16'(event_valid), 16'd1);
    checkOutput("pre_rst_held", 16'(key_held), 16'd1);
    reset = 1'b0;
    #1;
    checkOutput("rst_valid", 16'(event_valid), 16'd0);
    checkOutput("rst_data", 16'(event_data), 16'd0);
    checkOutput("rst_held", 16'(key_held), 16'd0);
    checkOutput("rst_code", 16'(key_code), 16'd0);
    checkOutput("rst_ovf", 16'(overflow), 16'd0);
    @(posedge clk);
    #1;
    dut_log.delete();
    event_ready = 1'b1;
    reset = 1'b1;
    applyStimulus(16'h8000, 20);
    checkLog("post_rst", 1, 5'h01, 5'h00, 5'h00, 5'h00);
    applyStimulus(16'h8000, 20);
    checkLog("post_rst_quiet", 1, 5'h01, 5'h00, 5'h00, 5'h00);
    checkOutput("post_rst_held", 16'(key_held), 16'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
